// File: rtl/int_issue_queue_pkg.sv
// Shared definitions for the integer issue queue.
// Holds the default physical-register and ROB index widths, plus ROB age
// helpers. The ROB and intblock call the same helpers.
// The helpers take 32-bit indices, so callers zero-extend. This lets one
// function serve any ROB_W up to 32.
package int_issue_queue_pkg;

  localparam int unsigned PREG_W_DEF = 6;
  localparam int unsigned ROB_W_DEF  = 5;

  // Ordering of two ROB ids, each given as a wrap flag plus an index.
  // When the flags are equal, the smaller index is older. When the flags
  // differ, the ROB has wrapped, so the larger index is older.
  function automatic logic is_older(input logic        flag_a,
                                    input logic [31:0] idx_a,
                                    input logic        flag_b,
                                    input logic [31:0] idx_b);
    return ((flag_a == flag_b) && (idx_a < idx_b)) ||
           ((flag_a != flag_b) && (idx_a > idx_b));
  endfunction

  // Returns 1 when the entry is strictly younger than the flushing
  // instruction. The flusher itself and everything older survive.
  function automatic logic is_killed(input logic        flush_flag,
                                     input logic [31:0] flush_idx,
                                     input logic        e_flag,
                                     input logic [31:0] e_idx);
    return (flush_flag ^ e_flag) ^ (flush_idx < e_idx);
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Interface bundling the issue queue's enqueue, wakeup, issue and flush
// channels.
//   enq_*   : renamed uop in; enq_ready goes back to rename
//   wk_*    : writeback wakeup broadcasts; port i uses wk_prd[i*PREG_W +: PREG_W]
//   issue_* : selected uop out to the execution block; issue_ready comes back
//   flush_* : redirect flush, given as the ROB id of the flushing instruction
// The master modport is the pipeline side, which drives the queue.
// The slave modport is the queue itself.
interface int_issue_queue_if #(
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned WK_PORTS  = 2
);
  logic                       enq_valid;
  logic                       enq_ready;
  logic [PREG_W-1:0]          enq_prs1;
  logic [PREG_W-1:0]          enq_prs2;
  logic                       enq_src1_rdy;
  logic                       enq_src2_rdy;
  logic                       enq_robidx_flag;
  logic [ROB_W-1:0]           enq_robidx;
  logic [PAYLOAD_W-1:0]       enq_payload;

  logic [WK_PORTS-1:0]        wk_valid;
  logic [WK_PORTS*PREG_W-1:0] wk_prd;

  logic                       issue_valid;
  logic                       issue_ready;
  logic [PREG_W-1:0]          issue_prs1;
  logic [PREG_W-1:0]          issue_prs2;
  logic                       issue_robidx_flag;
  logic [ROB_W-1:0]           issue_robidx;
  logic [PAYLOAD_W-1:0]       issue_payload;

  logic                       flush_valid;
  logic                       flush_robidx_flag;
  logic [ROB_W-1:0]           flush_robidx;

  modport master (
    output enq_valid, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
           enq_robidx_flag, enq_robidx, enq_payload,
    input  enq_ready,
    output wk_valid, wk_prd,
    input  issue_valid, issue_prs1, issue_prs2, issue_robidx_flag,
           issue_robidx, issue_payload,
    output issue_ready,
    output flush_valid, flush_robidx_flag, flush_robidx
  );

  modport slave (
    input  enq_valid, enq_prs1, enq_prs2, enq_src1_rdy, enq_src2_rdy,
           enq_robidx_flag, enq_robidx, enq_payload,
    output enq_ready,
    input  wk_valid, wk_prd,
    output issue_valid, issue_prs1, issue_prs2, issue_robidx_flag,
           issue_robidx, issue_payload,
    input  issue_ready,
    input  flush_valid, flush_robidx_flag, flush_robidx
  );
endinterface

// File: rtl/iq_age_select.sv
// Combinational oldest-candidate picker.
//   cand   : per-entry "ready to issue" mask
//   flag   : per-entry ROB wrap flag
//   idx    : per-entry ROB index
//   onehot : one-hot mask of the winning entry; all zeros when no candidate
//   sel    : binary slot number of the winner
//   any    : at least one candidate exists
// An entry wins when no other candidate is older than it.
// Two entries with identical ROB ids should never occur. If they do, the
// lower slot wins, so onehot always stays one-hot.
module iq_age_select
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROB_W = 5
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0]            flag,
  input  logic [DEPTH-1:0][ROB_W-1:0] idx,
  output logic [DEPTH-1:0]            onehot,
  output logic [$clog2(DEPTH)-1:0]    sel,
  output logic                        any
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic win;

  always_comb begin
    onehot = '0;
    win    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      win = cand[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] &&
            (is_older(flag[j], 32'(idx[j]), flag[i], 32'(idx[i])) ||
             (flag[j] == flag[i] && idx[j] == idx[i] && j < i)))
          win = 1'b0;
      end
      onehot[i] = win;
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (onehot[i]) sel = sel | IDX_W'(i);
  end

  assign any = |cand;

endmodule

// File: rtl/int_issue_queue.sv
// Out-of-order integer issue queue. It sits in front of the ALU/BJU/MULDIV
// block.
// Renamed uops wait here until both source pregs are ready. Each cycle, the
// oldest ready uop is issued.
// Entries never shift. A freed slot is refilled by the next enqueue, which
// always takes the lowest free slot.
// Ports:
//   clock     : all state updates on the rising edge
//   reset     : synchronous, active-high; clears every valid bit
//   iq        : enqueue / wakeup / issue / flush channels (slave side)
//   occupancy : number of valid entries
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = PREG_W_DEF,
  parameter int unsigned ROB_W     = ROB_W_DEF,
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned WK_PORTS  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  int_issue_queue_if.slave         iq,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;

  // Entry storage. Only the valid bits are reset.
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0]             rdy1;
  logic [DEPTH-1:0]             rdy2;
  logic [DEPTH-1:0]             flag;
  logic [DEPTH-1:0][ROB_W-1:0]  robidx;
  logic [DEPTH-1:0][PREG_W-1:0] prs1;
  logic [DEPTH-1:0][PREG_W-1:0] prs2;
  logic [PAYLOAD_W-1:0]         payload [DEPTH];

  logic [DEPTH-1:0] wake1, wake2, kill, cand, sel_onehot;
  logic             enq_wake1, enq_wake2, enq_kill;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             sel_any, enq_fire, issue_fire;

  // Wakeup compare for the stored entries and for the incoming uop.
  // Matching the incoming uop too means a broadcast in the enqueue cycle
  // is not lost.
  always_comb begin
    wake1     = '0;
    wake2     = '0;
    enq_wake1 = 1'b0;
    enq_wake2 = 1'b0;
    for (int unsigned p = 0; p < WK_PORTS; p++) begin
      if (iq.wk_valid[p]) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (iq.wk_prd[p*PREG_W +: PREG_W] == prs1[i]) wake1[i] = 1'b1;
          if (iq.wk_prd[p*PREG_W +: PREG_W] == prs2[i]) wake2[i] = 1'b1;
        end
        if (iq.wk_prd[p*PREG_W +: PREG_W] == iq.enq_prs1) enq_wake1 = 1'b1;
        if (iq.wk_prd[p*PREG_W +: PREG_W] == iq.enq_prs2) enq_wake2 = 1'b1;
      end
    end
  end

  // Flush kill mask. The incoming uop is tested with the same predicate.
  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      kill[i] = valid[i] && iq.flush_valid &&
                is_killed(iq.flush_robidx_flag, 32'(iq.flush_robidx),
                          flag[i], 32'(robidx[i]));
    enq_kill = iq.flush_valid &&
               is_killed(iq.flush_robidx_flag, 32'(iq.flush_robidx),
                         iq.enq_robidx_flag, 32'(iq.enq_robidx));
  end

  // Lowest free slot. The loop runs downward, so the lowest index is the
  // last assignment and wins.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (!valid[i-1]) free_idx = IDX_W'(i - 1);
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      occupancy = occupancy + OCC_W'(valid[i]);
  end

  assign cand = valid & rdy1 & rdy2;

  iq_age_select #(
    .DEPTH (DEPTH),
    .ROB_W (ROB_W)
  ) u_age_select (
    .cand   (cand),
    .flag   (flag),
    .idx    (robidx),
    .onehot (sel_onehot),
    .sel    (sel_idx),
    .any    (sel_any)
  );

  // enq_ready depends only on registered state. A slot freed by this
  // cycle's issue cannot be refilled in the same cycle.
  assign iq.enq_ready         = ~&valid;
  assign iq.issue_valid       = sel_any && !kill[sel_idx];
  assign iq.issue_prs1        = prs1[sel_idx];
  assign iq.issue_prs2        = prs2[sel_idx];
  assign iq.issue_robidx_flag = flag[sel_idx];
  assign iq.issue_robidx      = robidx[sel_idx];
  assign iq.issue_payload     = payload[sel_idx];

  assign enq_fire   = iq.enq_valid && iq.enq_ready;
  assign issue_fire = iq.issue_valid && iq.issue_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill[i] || (issue_fire && sel_onehot[i])) begin
          valid[i] <= 1'b0;
        end else begin
          if (wake1[i]) rdy1[i] <= 1'b1;
          if (wake2[i]) rdy2[i] <= 1'b1;
        end
      end
      // The free slot is never valid, so this write cannot collide with
      // the clears above.
      if (enq_fire && !enq_kill) begin
        valid[free_idx]   <= 1'b1;
        rdy1[free_idx]    <= iq.enq_src1_rdy | enq_wake1;
        rdy2[free_idx]    <= iq.enq_src2_rdy | enq_wake2;
        flag[free_idx]    <= iq.enq_robidx_flag;
        robidx[free_idx]  <= iq.enq_robidx;
        prs1[free_idx]    <= iq.enq_prs1;
        prs2[free_idx]    <= iq.enq_prs2;
        payload[free_idx] <= iq.enq_payload;
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
module tb_int_issue_queue;

  logic       clock;
  logic       reset;
  logic [3:0] occ;

  int checks;
  int errors;

  int_issue_queue_if #(
    .PREG_W    (6),
    .ROB_W     (5),
    .PAYLOAD_W (256),
    .WK_PORTS  (2)
  ) bus ();

  int_issue_queue #(
    .DEPTH     (8),
    .PREG_W    (6),
    .ROB_W     (5),
    .PAYLOAD_W (256),
    .WK_PORTS  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iq        (bus),
    .occupancy (occ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [5:0] p1, p2;
    logic       r1, r2, ef;
    logic [4:0] ei;
    logic       ir;
    logic [1:0] wkv;
    logic [5:0] wk0, wk1;
    logic       fv, ff;
    logic [4:0] fi;
    logic       xiv, xf;
    logic [4:0] xi;
    logic [3:0] xocc;
    logic       xer;
  } vec_t;

  vec_t vq[$];

  function automatic logic [255:0] pay(input logic f, input logic [4:0] idx);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < 8; k++)
      p[k*32 +: 32] = 32'hC0DE_0000 ^ (32'(k) << 8) ^ 32'({f, idx});
    return p;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.enq_valid = 0; bus.enq_prs1 = 0; bus.enq_prs2 = 0;
    bus.enq_src1_rdy = 0; bus.enq_src2_rdy = 0;
    bus.enq_robidx_flag = 0; bus.enq_robidx = 0; bus.enq_payload = '0;
    bus.wk_valid = 0; bus.wk_prd = 0;
    bus.flush_valid = 0; bus.flush_robidx_flag = 0; bus.flush_robidx = 0;
  endtask

  task automatic set_enq(input logic [5:0] p1, input logic [5:0] p2, input logic r1,
                         input logic r2, input logic f, input logic [4:0] idx);
    bus.enq_valid = 1; bus.enq_prs1 = p1; bus.enq_prs2 = p2;
    bus.enq_src1_rdy = r1; bus.enq_src2_rdy = r2;
    bus.enq_robidx_flag = f; bus.enq_robidx = idx; bus.enq_payload = pay(f, idx);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic av(input logic en, input logic [5:0] p1, input logic [5:0] p2,
                    input logic r1, input logic r2, input logic ef, input logic [4:0] ei,
                    input logic ir, input logic [1:0] wkv, input logic [5:0] wk0,
                    input logic [5:0] wk1, input logic fv, input logic ff,
                    input logic [4:0] fi, input logic xiv, input logic xf,
                    input logic [4:0] xi, input logic [3:0] xocc, input logic xer);
    vec_t v;
    v.en = en; v.p1 = p1; v.p2 = p2; v.r1 = r1; v.r2 = r2; v.ef = ef; v.ei = ei;
    v.ir = ir; v.wkv = wkv; v.wk0 = wk0; v.wk1 = wk1; v.fv = fv; v.ff = ff; v.fi = fi;
    v.xiv = xiv; v.xf = xf; v.xi = xi; v.xocc = xocc; v.xer = xer;
    vq.push_back(v);
  endtask

  task automatic apply(input int n, input vec_t v);
    idle();
    if (v.en) set_enq(v.p1, v.p2, v.r1, v.r2, v.ef, v.ei);
    bus.issue_ready = v.ir;
    bus.wk_valid = v.wkv;
    bus.wk_prd = {v.wk1, v.wk0};
    bus.flush_valid = v.fv; bus.flush_robidx_flag = v.ff; bus.flush_robidx = v.fi;
    #1;
    chk($sformatf("v%0d issue_valid", n), 256'(bus.issue_valid), 256'(v.xiv));
    if (v.xiv) begin
      chk($sformatf("v%0d issue_rob", n), 256'({bus.issue_robidx_flag, bus.issue_robidx}),
          256'({v.xf, v.xi}));
      chk($sformatf("v%0d issue_payload", n), bus.issue_payload, pay(v.xf, v.xi));
    end
    chk($sformatf("v%0d occupancy", n), 256'(occ), 256'(v.xocc));
    chk($sformatf("v%0d enq_ready", n), 256'(bus.enq_ready), 256'(v.xer));
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1;
    idle();
    bus.issue_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset occupancy", 256'(occ), 256'(0));
    chk("reset enq_ready", 256'(bus.enq_ready), 256'(1));
    chk("reset issue_valid", 256'(bus.issue_valid), 256'(0));
    reset = 0;

    // Fill the queue with issue blocked, then drain it in ROB order.
    for (int k = 0; k < 8; k++)
      av(1, 1, 2, 1, 1, 0, 5'(k), 0, 0, 0, 0, 0, 0, 0, k > 0, 0, 0, 4'(k), 1);
    av(1, 1, 2, 1, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 0); // full: enq dropped
    for (int k = 1; k < 8; k++)
      av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'(k), 4'(8 - k), 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // A younger, ready uop bypasses an older one that is not ready;
    // a wakeup then releases the older one.
    av(1, 12, 3, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    av(1, 4, 5, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 1, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Wakeup on port 1 in the same cycle as the enqueue.
    av(1, 7, 20, 1, 0, 0, 10, 1, 2'b10, 0, 20, 0, 0, 0, 0, 0, 0, 0, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 10, 1, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Age order across the ROB wrap: 30,31 (flag 0) come before 1,2 (flag 1).
    av(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    av(1, 1, 2, 1, 1, 0, 31, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
    av(1, 1, 2, 1, 1, 0, 30, 0, 0, 0, 0, 0, 0, 0, 1, 0, 31, 2, 1);
    av(1, 1, 2, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 30, 3, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 31, 3, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1);
    av(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vq[n]) apply(n, vq[n]);

    // Flush kills rob6 (currently selected) and the enqueuing rob7.
    idle();
    bus.issue_ready = 0;
    set_enq(40, 1, 0, 1, 0, 2); step();
    set_enq(40, 1, 0, 1, 0, 4); step();
    set_enq(1, 2, 1, 1, 0, 6);  step();
    idle(); #1;
    chk("flush pre selected", 256'({bus.issue_valid, bus.issue_robidx}), 256'({1'b1, 5'd6}));
    bus.issue_ready = 1;
    set_enq(1, 2, 1, 1, 0, 7);
    bus.flush_valid = 1; bus.flush_robidx_flag = 0; bus.flush_robidx = 4;
    #1;
    chk("flush issue_valid", 256'(bus.issue_valid), 256'(0));
    step();
    idle(); #1;
    chk("flush occupancy", 256'(occ), 256'(2));
    chk("flush survivors idle", 256'(bus.issue_valid), 256'(0));
    bus.wk_valid = 2'b01; bus.wk_prd = 12'(40);
    step();
    idle(); #1;
    chk("flush rob2", 256'({bus.issue_valid, bus.issue_robidx}), 256'({1'b1, 5'd2}));
    step();
    chk("flush rob4", 256'({bus.issue_valid, bus.issue_robidx}), 256'({1'b1, 5'd4}));
    chk("flush rob4 occ", 256'(occ), 256'(1));
    step();
    chk("flush drained", 256'(occ), 256'(0));

    // A flush after the ROB has wrapped keeps the older flag-0 entry.
    bus.issue_ready = 0;
    set_enq(1, 2, 1, 1, 0, 30); step();
    idle();
    bus.flush_valid = 1; bus.flush_robidx_flag = 1; bus.flush_robidx = 1;
    step();
    idle(); #1;
    chk("wrap flush survivor occ", 256'(occ), 256'(1));
    chk("wrap flush survivor", 256'({bus.issue_valid, bus.issue_robidx}), 256'({1'b1, 5'd30}));
    bus.issue_ready = 1;
    step();
    chk("wrap flush drained", 256'(occ), 256'(0));

    // Back-pressure holds the entry. Reset then discards it.
    bus.issue_ready = 0;
    set_enq(33, 34, 1, 1, 0, 9); step();
    idle(); #1;
    chk("hold c0 valid", 256'({bus.issue_valid, bus.issue_robidx}), 256'({1'b1, 5'd9}));
    chk("hold c0 prs", 256'({bus.issue_prs1, bus.issue_prs2}), 256'({6'd33, 6'd34}));
    chk("hold c0 payload", bus.issue_payload, pay(0, 9));
    step();
    chk("hold c1 valid", 256'(bus.issue_valid), 256'(1));
    chk("hold c1 payload", bus.issue_payload, pay(0, 9));
    chk("hold c1 occ", 256'(occ), 256'(1));
    step();
    reset = 1; #1;
    chk("hold c2 payload", bus.issue_payload, pay(0, 9));
    step();
    reset = 0;
    chk("post reset occ", 256'(occ), 256'(0));
    chk("post reset issue_valid", 256'(bus.issue_valid), 256'(0));
    chk("post reset enq_ready", 256'(bus.enq_ready), 256'(1));
    step();
    chk("post reset occ later", 256'(occ), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
